// File: rtl/bits_req_sched.sv
// rtl/bits_req_sched.sv - bit buffer request sequencer between the word FIFO and the bit consumer
// Buffer is MSB-aligned: valid bits occupy buf_q[63 -: level_q], everything below is zero.
module bits_req_sched (
  input  logic        clock,
  input  logic        reset,
  input  logic        fifo_empty,
  output logic        fifo_pop,
  input  logic [31:0] fifo_data,
  input  logic        reqin,
  input  logic [3:0]  reqlen,
  output logic        pushout,
  output logic [3:0]  lenout,
  output logic [14:0] dataout,
  output logic        busy,
  output logic [6:0]  level
);

  localparam int BUFW   = 64;
  localparam int MAXREQ = 15;

  typedef enum logic {IDLE, PEND} state_t;

  state_t            state_q, state_d;
  logic [BUFW-1:0]   buf_q, buf_d;
  logic [6:0]        level_q, level_d;
  logic [3:0]        pend_len_q, pend_len_d;
  logic              pop_q, pop_d;
  logic              arrive_q, arrive_d;
  logic              pushout_q, pushout_d;
  logic [3:0]        lenout_q, lenout_d;
  logic [MAXREQ-1:0] dataout_q, dataout_d;
  logic              busy_q, busy_d;

  logic              serve;
  logic [3:0]        slen;
  logic [6:0]        lvl_after;
  logic [BUFW-1:0]   shifted;
  logic [MAXREQ-1:0] top_bits;

  always_comb begin
    state_d    = state_q;
    pend_len_d = pend_len_q;
    serve      = 1'b0;
    slen       = 4'd0;

    case (state_q)
      IDLE: begin
        if (reqin) begin
          if (level_q >= {3'b000, reqlen}) begin
            serve = 1'b1;
            slen  = reqlen;
          end else begin
            state_d    = PEND;
            pend_len_d = reqlen;
          end
        end
      end
      PEND: begin
        if (level_q >= {3'b000, pend_len_q}) begin
          serve   = 1'b1;
          slen    = pend_len_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d    = (state_d == PEND);
    pushout_d = serve;
    top_bits  = buf_q[BUFW-1 -: MAXREQ];
    lenout_d  = serve ? slen : lenout_q;
    dataout_d = serve ? (top_bits >> (4'd15 - slen)) : dataout_q;

    // Serve works on the pre-append buffer; the arriving word lands just below what survives.
    shifted   = serve ? (buf_q << slen) : buf_q;
    lvl_after = level_q - (serve ? {3'b000, slen} : 7'd0);
    if (arrive_q) begin
      buf_d   = shifted | ({fifo_data, 32'h0} >> lvl_after);
      level_d = lvl_after + 7'd32;
    end else begin
      buf_d   = shifted;
      level_d = lvl_after;
    end

    // One fetch in flight covers both the pop cycle and the data-return cycle.
    pop_d    = (level_q <= 7'd32) && !fifo_empty && !pop_q && !arrive_q;
    arrive_d = pop_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      buf_q      <= '0;
      level_q    <= '0;
      pend_len_q <= '0;
      pop_q      <= 1'b0;
      arrive_q   <= 1'b0;
      pushout_q  <= 1'b0;
      lenout_q   <= '0;
      dataout_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      level_q    <= level_d;
      pend_len_q <= pend_len_d;
      pop_q      <= pop_d;
      arrive_q   <= arrive_d;
      pushout_q  <= pushout_d;
      lenout_q   <= lenout_d;
      dataout_q  <= dataout_d;
      busy_q     <= busy_d;
    end
  end

  assign fifo_pop = pop_q;
  assign pushout  = pushout_q;
  assign lenout   = lenout_q;
  assign dataout  = dataout_q;
  assign busy     = busy_q;
  assign level    = level_q;

endmodule

// File: tb/tb_bits_req_sched.sv
// tb/tb_bits_req_sched.sv - scoreboard bench for bits_req_sched with a bit-stream reference
module tb_bits_req_sched;

  logic        clock;
  logic        reset;
  logic        fifo_empty;
  logic        fifo_pop;
  logic [31:0] fifo_data = '0;
  logic        reqin;
  logic [3:0]  reqlen;
  logic        pushout;
  logic [3:0]  lenout;
  logic [14:0] dataout;
  logic        busy;
  logic [6:0]  level;

  typedef struct {
    logic [3:0]  len;
    logic [14:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] fifo_q[$];
  bit          ref_bits[$];
  logic [31:0] words[1000];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_fail = 0;

  bits_req_sched dut (
    .clock(clock), .reset(reset), .fifo_empty(fifo_empty), .fifo_pop(fifo_pop),
    .fifo_data(fifo_data), .reqin(reqin), .reqlen(reqlen), .pushout(pushout),
    .lenout(lenout), .dataout(dataout), .busy(busy), .level(level)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign fifo_empty = (fifo_q.size() == 0);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [3:0] l, input logic [14:0] d);
    exp_t e;
    e.len  = l;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic step();
    @(negedge clock);
    #2;
  endtask

  // Monitor: scoreboard pop on pushout, registered-read FIFO model, level bound.
  always @(negedge clock) begin
    if (reset) begin
      if (pushout) begin
        if (sb.size() == 0) begin
          chk("unexpected_pushout", {28'h0, lenout}, 32'hFFFF_FFFF);
        end else begin
          mon_e = sb.pop_front();
          chk("lenout", {28'h0, lenout}, {28'h0, mon_e.len});
          chk("dataout", {17'h0, dataout}, {17'h0, mon_e.data});
        end
      end
      chk("level_max", {31'h0, (level > 7'd64)}, 32'h0);
      if (fifo_pop) begin
        chk("pop_when_empty", {31'h0, (fifo_q.size() == 0)}, 32'h0);
        if (fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
      end
    end
  end

  task automatic do_reset();
    reset = 1'b0;
    reqin = 1'b0;
    reqlen = 4'd0;
    fifo_q.delete();
    sb.delete();
    repeat (2) step();
    chk("rst_level", {25'h0, level}, 32'h0);
    chk("rst_flags", {29'h0, busy, pushout, fifo_pop}, 32'h0);
    chk("rst_out", {13'h0, lenout, dataout}, 32'h0);
    reset = 1'b1;
  endtask

  task automatic wait_level(input logic [6:0] t, input int budget);
    int n = 0;
    while (level !== t && n < budget) begin
      step();
      n++;
    end
    chk("wait_level", {25'h0, level}, {25'h0, t});
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() > 0 && n < budget) begin
      step();
      n++;
    end
    chk("scoreboard_drain", sb.size(), 0);
  endtask

  initial begin
    int widx;
    int cyc;
    int mx;
    int l;
    logic [14:0] d;

    reset = 1'b0;
    reqin = 1'b0;
    reqlen = 4'd0;

    // Basic serve sequence from one word.
    do_reset();
    fifo_q.push_back(32'hA5A5F00F);
    wait_level(7'd32, 20);
    reqin = 1'b1; reqlen = 4'd4; push_exp(4'd4, 15'h000A);
    step();
    chk("hit_latency", {31'h0, pushout}, 32'h1);
    reqlen = 4'd8; push_exp(4'd8, 15'h005A);
    step();
    reqlen = 4'd15; push_exp(4'd15, 15'h2F80);
    step();
    reqin = 1'b0;
    repeat (2) step();
    chk("t1_level", {25'h0, level}, 32'd5);
    wait_drain(10);

    // Miss from empty buffer and empty FIFO.
    do_reset();
    step();
    reqin = 1'b1; reqlen = 4'd15;
    step();
    reqin = 1'b0;
    chk("miss_busy", {31'h0, busy}, 32'h1);
    chk("miss_no_push", {31'h0, pushout}, 32'h0);
    repeat (3) begin
      step();
      chk("miss_hold", {30'h0, busy, pushout}, 32'h2);
    end
    push_exp(4'd15, 15'h7FFF);
    fifo_q.push_back(32'hFFFF0000);
    step();
    chk("miss_pop", {31'h0, fifo_pop}, 32'h1);
    step();
    chk("miss_wait1", {31'h0, pushout}, 32'h0);
    step();
    chk("miss_wait2", {31'h0, pushout}, 32'h0);
    step();
    chk("miss_push", {31'h0, pushout}, 32'h1);
    chk("miss_busy_clr", {31'h0, busy}, 32'h0);
    chk("miss_level", {25'h0, level}, 32'd17);
    wait_drain(5);

    // Word boundary straddle.
    do_reset();
    fifo_q.push_back(32'h0000000F);
    fifo_q.push_back(32'hF0000000);
    wait_level(7'd64, 30);
    reqin = 1'b1; reqlen = 4'd15; push_exp(4'd15, 15'h0000);
    step();
    push_exp(4'd15, 15'h0003);
    step();
    reqlen = 4'd6; push_exp(4'd6, 15'h003F);
    step();
    reqin = 1'b0;
    wait_drain(10);
    chk("straddle_level", {25'h0, level}, 32'd28);

    // Zero-length request on an empty buffer.
    do_reset();
    step();
    reqin = 1'b1; reqlen = 4'd0; push_exp(4'd0, 15'h0);
    step();
    reqin = 1'b0;
    chk("zero_push", {31'h0, pushout}, 32'h1);
    chk("zero_busy_pop", {30'h0, busy, fifo_pop}, 32'h0);
    step();
    chk("zero_level", {25'h0, level}, 32'h0);
    chk("zero_no_pop", {31'h0, fifo_pop}, 32'h0);
    wait_drain(5);

    // Asynchronous reset while a request is pending.
    do_reset();
    fifo_q.push_back(32'hFFFFFFFF);
    wait_level(7'd32, 20);
    reqin = 1'b1; reqlen = 4'd15; push_exp(4'd15, 15'h7FFF);
    step();
    push_exp(4'd15, 15'h7FFF);
    step();
    step();
    reqin = 1'b0;
    chk("pend_busy", {31'h0, busy}, 32'h1);
    chk("pend_level", {25'h0, level}, 32'd2);
    #1 reset = 1'b0;
    #1;
    chk("async_rst", {22'h0, busy, pushout, fifo_pop, level}, 32'h0);
    do_reset();
    fifo_q.push_back(32'h30000000);
    wait_level(7'd32, 20);
    reqin = 1'b1; reqlen = 4'd4; push_exp(4'd4, 15'h0003);
    step();
    reqin = 1'b0;
    wait_drain(5);

    // Random stream against the concatenated bit-stream reference.
    do_reset();
    ref_bits.delete();
    for (int w = 0; w < 1000; w++) begin
      words[w] = $urandom;
      for (int b = 31; b >= 0; b--) ref_bits.push_back(words[w][b]);
    end
    widx = 0;
    cyc = 0;
    while ((widx < 1000 || ref_bits.size() > 0) && cyc < 30000) begin
      step();
      reqin = 1'b0;
      if (widx < 1000 && fifo_q.size() < 4 && $urandom_range(0, 3) != 0) begin
        fifo_q.push_back(words[widx]);
        widx++;
      end
      if (!busy && $urandom_range(0, 4) != 0) begin
        mx = (ref_bits.size() < 15) ? ref_bits.size() : 15;
        l = int'($urandom_range(0, mx));
        d = '0;
        for (int i = 0; i < l; i++) d = {d[13:0], ref_bits.pop_front()};
        push_exp(4'(l), d);
        reqin = 1'b1;
        reqlen = 4'(l);
      end
      cyc++;
    end
    step();
    reqin = 1'b0;
    chk("random_budget", {31'h0, (cyc >= 30000)}, 32'h0);
    wait_drain(200);
    repeat (2) step();
    chk("random_final_level", {25'h0, level}, 32'h0);
    chk("random_fifo_empty", fifo_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
